// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Small loadable program memory that feeds the processor's instruction input.
//   A program counter walks the memory from address 0. Each fetched
//   instruction is held on iin until the processor pulses done, and the run
//   stops after the latched number of instructions.
//
// Ports
//   clock     in   system clock, rising edge
//   resetn    in   asynchronous active-low reset
//   wr_en     in   program memory write strobe (accepted only when not busy)
//   wr_addr   in   [ADDR_WIDTH]    write address
//   wr_data   in   [DATA_WIDTH]    write data
//   prog_len  in   [ADDR_WIDTH+1]  instruction count, sampled on start
//   start     in   begin execution from address 0 (ignored while busy)
//   done      in   processor finished the current instruction (used in WAIT only)
//   iin       out  [DATA_WIDTH]    instruction presented to the processor
//   iin_valid out  iin holds a valid, unconsumed instruction
//   pc        out  [ADDR_WIDTH]    address of the instruction in iin
//   busy      out  a program is running
//   halted    out  the last program has completed
module instr_fetch_unit #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH:0]   prog_len,
  input  logic                  start,
  input  logic                  done,
  output logic [DATA_WIDTH-1:0] iin,
  output logic                  iin_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE  = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] iin_q, iin_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  halted_q, halted_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we;
  logic [ADDR_WIDTH:0]   start_len;
  logic                  last_instr;

  // Writes are locked out for the whole run so the program cannot change
  // underneath the fetch sequence.
  assign mem_we = wr_en && ((state_q == S_IDLE) || (state_q == S_HALT));

  // Requested lengths beyond the memory size run the whole memory once.
  assign start_len = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;

  // Compare pc+1 against len in the wider width so a full-depth run ends at
  // pc=DEPTH-1 without the pc itself ever wrapping.
  assign last_instr = (({1'b0, pc_q} + LEN_ONE) == len_q);

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    iin_d    = iin_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    halted_d = halted_q;
    len_d    = len_q;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d  = '0;
          len_d = start_len;
          if (prog_len == '0) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            state_d  = S_FETCH;
            busy_d   = 1'b1;
            halted_d = 1'b0;
          end
        end
      end

      S_FETCH: begin
        iin_d   = mem_q[pc_q];
        valid_d = 1'b1;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (done) begin
          valid_d = 1'b0;
          if (last_instr) begin
            busy_d   = 1'b0;
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            pc_d    = pc_q + PC_ONE;
            state_d = S_FETCH;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      iin_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      iin_q    <= iin_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      len_q    <= len_d;
    end
  end

  assign iin       = iin_q;
  assign iin_valid = valid_q;
  assign pc        = pc_q;
  assign busy      = busy_q;
  assign halted    = halted_q;

endmodule
